// File: rtl/toggle_pulse_gen.sv
// ---------------------------------------------------------------------------
// toggle_pulse_gen
//   Turns a raw, bouncing push-button level into a clean single-cycle toggle
//   request for a downstream T flip-flop. The raw level is brought into the
//   clock domain by a two-flop synchroniser. A four-state FSM with a small
//   counter then debounces it. Each qualified press (low->high) produces one
//   cycle of t. A wrapping press counter is kept for debug.
//
// Ports
//   clk          in   1       rising-edge clock, the only clock
//   rst          in   1       synchronous, active-high reset
//   btn_in       in   1       raw button level, asynchronous to clk, may bounce
//   t            out  1       one-cycle toggle request (registered)
//   btn_stable   out  1       debounced, synchronised button level (registered)
//   press_count  out  PCNT_W  number of t pulses since reset, wraps
// ---------------------------------------------------------------------------
module toggle_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4,
    parameter int PCNT_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_in,
    output logic              t,
    output logic              btn_stable,
    output logic [PCNT_W-1:0] press_count
);

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CHK_HI  = 2'd1,
        IDLE_HI = 2'd2,
        CHK_LO  = 2'd3
    } state_e;

    // A level is accepted on the sample that brings the run of new-level
    // samples to DEBOUNCE_CYCLES. The counter holds the run length so far.
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = '0;
    localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);
    localparam logic [PCNT_W-1:0] PCNT_ZERO = '0;

    logic              sync1_q;
    logic              sync2_q;
    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              t_q;
    logic              t_d;
    logic              stable_q;
    logic              stable_d;
    logic [PCNT_W-1:0] pcnt_q;
    logic [PCNT_W-1:0] pcnt_d;

    // Next-state and next-output logic of the debounce FSM. It looks only at sync2_q.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        t_d      = 1'b0;
        stable_d = stable_q;
        pcnt_d   = pcnt_q;
        case (state_q)
            IDLE_LO: begin
                if (sync2_q) begin
                    state_d = CHK_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = IDLE_LO;
                end
            end
            CHK_HI: begin
                if (!sync2_q) begin
                    // Bounce: drop the partial qualification, no pulse.
                    state_d = IDLE_LO;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = IDLE_HI;
                    stable_d = 1'b1;
                    t_d      = 1'b1;
                    cnt_d    = CNT_ZERO;
                    pcnt_d   = pcnt_q + PCNT_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            IDLE_HI: begin
                if (!sync2_q) begin
                    state_d = CHK_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = IDLE_HI;
                end
            end
            CHK_LO: begin
                if (sync2_q) begin
                    state_d = IDLE_HI;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    // A release is accepted silently. Only presses request a toggle.
                    state_d  = IDLE_LO;
                    stable_d = 1'b0;
                    cnt_d    = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d  = IDLE_LO;
                cnt_d    = CNT_ZERO;
                stable_d = 1'b0;
            end
        endcase
    end

    // State, synchroniser and output registers. Reset has priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            state_q  <= IDLE_LO;
            cnt_q    <= CNT_ZERO;
            t_q      <= 1'b0;
            stable_q <= 1'b0;
            pcnt_q   <= PCNT_ZERO;
        end else begin
            sync1_q  <= btn_in;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            t_q      <= t_d;
            stable_q <= stable_d;
            pcnt_q   <= pcnt_d;
        end
    end

    assign t           = t_q;
    assign btn_stable  = stable_q;
    assign press_count = pcnt_q;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
module tb_toggle_pulse_gen;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_in = 1'b0;
    logic       t;
    logic       btn_stable;
    logic [7:0] press_count;

    toggle_pulse_gen #(.DEBOUNCE_CYCLES(D), .CNT_W(4), .PCNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .t          (t),
        .btn_stable (btn_stable),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model state. The last two sampled button levels model the
    // synchroniser. The run length counts consecutive samples that differ
    // from the accepted level.
    bit m_s1 = 1'b0;
    bit m_s2 = 1'b0;
    bit m_stable = 1'b0;
    bit m_t = 1'b0;
    bit m_q = 1'b0;
    int m_run = 0;
    int m_pc = 0;
    int q_cyc[$];
    int q_cnt[$];
    int exp_cyc;
    int exp_cnt;

    logic tff_q = 1'b0;
    always @(posedge clk) tff_q <= rst ? 1'b0 : (t ? ~tff_q : tff_q);

    task automatic step(input logic r, input logic b);
        bit sample;
        cyc++;
        m_t = 1'b0;
        if (r) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_stable = 1'b0; m_run = 0; m_pc = 0;
        end else begin
            sample = m_s2;
            m_s2   = m_s1;
            m_s1   = b;
            if (sample != m_stable) begin
                m_run++;
                if (m_run == D) begin
                    m_stable = sample;
                    m_run    = 0;
                    if (sample) begin
                        m_pc = (m_pc + 1) % 256;
                        m_t  = 1'b1;
                        q_cyc.push_back(cyc);
                        q_cnt.push_back(m_pc);
                    end
                end
            end else begin
                m_run = 0;
            end
        end
        // Downstream T flip-flop as seen one edge after the t pulse.
        if (r) m_q = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare levels every cycle and pop the scoreboard on each pulse.
    always @(negedge clk) begin
        check("btn_stable", {31'd0, btn_stable}, {31'd0, m_stable});
        check("t", {31'd0, t}, {31'd0, m_t});
        check("press_count", {24'd0, press_count}, m_pc);
        check("tff_q", {31'd0, tff_q}, {31'd0, m_q});
        if (t === 1'b1) begin
            if (q_cyc.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL pulse_unexpected at cycle %0d: got t=1, expected no pulse", cyc);
            end else begin
                exp_cyc = q_cyc.pop_front();
                exp_cnt = q_cnt.pop_front();
                check("pulse_cycle", cyc, exp_cyc);
                check("pulse_count", {24'd0, press_count}, exp_cnt);
            end
            m_q = ~m_q;
        end
    end

    task automatic drive(input logic r, input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst    = r;
            btn_in = b;
            @(posedge clk);
            step(r, b);
        end
    endtask

    initial begin
        // Reset with the button held high, then released while still high.
        drive(1'b1, 1'b1, 2);
        drive(1'b0, 1'b1, 10);
        drive(1'b0, 1'b0, 10);
        // Clean press and release.
        drive(1'b0, 1'b1, 10);
        drive(1'b0, 1'b0, 6);
        // Bounce, then settle high.
        drive(1'b0, 1'b1, 1);
        drive(1'b0, 1'b0, 1);
        drive(1'b0, 1'b1, 1);
        drive(1'b0, 1'b0, 1);
        drive(1'b0, 1'b1, 10);
        // Release held low.
        drive(1'b0, 1'b0, 6);
        drive(1'b0, 1'b0, 4);
        // Short glitch must not qualify.
        drive(1'b0, 1'b1, 3);
        drive(1'b0, 1'b0, 8);
        // Reset in the middle of a high qualification.
        drive(1'b0, 1'b1, 5);
        drive(1'b1, 1'b1, 1);
        drive(1'b0, 1'b0, 8);
        // 256 clean presses wrap the counter back to its start value.
        for (int p = 0; p < 256; p++) begin
            drive(1'b0, 1'b1, 7);
            drive(1'b0, 1'b0, 7);
        end
        // Random bouncing with an occasional reset.
        for (int s = 0; s < 400; s++) begin
            if ($urandom_range(0, 39) == 0)
                drive(1'b1, 1'($urandom_range(0, 1)), 1);
            else
                drive(1'b0, 1'($urandom_range(0, 1)), $urandom_range(1, 8));
        end
        drive(1'b0, 1'b0, 10);
        @(negedge clk);
        check("scoreboard_empty", q_cyc.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
